// File: rtl/srpt_pkg.sv
// Shared entry layout, priority codes and ordering helpers for the SRPT fetch queue.
package srpt_pkg;

  localparam int RPC_ID_W   = 16;
  localparam int DBUFF_ID_W = 10;
  localparam int BYTES_W    = 20;
  localparam int PRIO_W     = 3;

  // Bit offsets of each field inside a flat entry word (LSB first).
  localparam int RPC_ID_LSB    = 0;
  localparam int DBUFF_ID_LSB  = RPC_ID_LSB + RPC_ID_W;
  localparam int REMAINING_LSB = DBUFF_ID_LSB + DBUFF_ID_W;
  localparam int DBUFFERED_LSB = REMAINING_LSB + BYTES_W;
  localparam int GRANTED_LSB   = DBUFFERED_LSB + BYTES_W;
  localparam int PRIO_LSB      = GRANTED_LSB + BYTES_W;
  localparam int ENTRY_W       = PRIO_LSB + PRIO_W;

  localparam logic [PRIO_W-1:0] PRIO_EMPTY   = 3'd3;
  localparam logic [PRIO_W-1:0] PRIO_BLOCKED = 3'd4;
  localparam logic [PRIO_W-1:0] PRIO_ACTIVE  = 3'd5;

  // Declared MSB first so the packed layout matches the offsets above.
  typedef struct packed {
    logic [PRIO_W-1:0]     prio;
    logic [BYTES_W-1:0]    granted;
    logic [BYTES_W-1:0]    dbuffered;
    logic [BYTES_W-1:0]    remaining;
    logic [DBUFF_ID_W-1:0] dbuff_id;
    logic [RPC_ID_W-1:0]   rpc_id;
  } entry_t;

  localparam entry_t ENTRY_EMPTY = '{PRIO_EMPTY, 20'd0, 20'd0, 20'd0, 10'd0, 16'd0};

  // True when x strictly outranks y; full ties report false so entries hold position.
  function automatic logic better(entry_t x, entry_t y);
    if (x.prio != y.prio) return x.prio > y.prio;
    return x.remaining < y.remaining;
  endfunction

  // Raise GRANTED on a matching live entry and unblock it once it has credit again.
  function automatic entry_t apply_grant(entry_t e, logic vld,
                                         logic [RPC_ID_W-1:0] id,
                                         logic [BYTES_W-1:0] bytes);
    entry_t r;
    r = e;
    if (vld && e.rpc_id == id && e.prio != PRIO_EMPTY) begin
      if (bytes > e.granted) r.granted = bytes;
      if (e.prio == PRIO_BLOCKED && r.granted > e.dbuffered) r.prio = PRIO_ACTIVE;
    end
    return r;
  endfunction

endpackage

// File: rtl/srpt_cmp_swap.sv
// Compare-exchange of two queue entries: the better one leaves on lo, the other on hi.
module srpt_cmp_swap
  import srpt_pkg::*;
(
  input  entry_t a,
  input  entry_t b,
  output entry_t lo,
  output entry_t hi
);

  logic swap;

  // a sits at the lower index; swap only when b strictly outranks it.
  assign swap = better(b, a);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/srpt_fetch_sched.sv
// Shortest-remaining-first fetch scheduler: sorted entry array with the head at slot 0.
module srpt_fetch_sched
  import srpt_pkg::*;
#(
  parameter int MAX_RPCS         = 64,
  parameter int CACHE_BLOCK_SIZE = 64,
  parameter int CNT_W            = $clog2(MAX_RPCS + 1)
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [ENTRY_W-1:0]  in_data_i,
  input  logic                grant_valid_i,
  input  logic [RPC_ID_W-1:0] grant_rpc_id_i,
  input  logic [BYTES_W-1:0]  grant_bytes_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [ENTRY_W-1:0]  out_data_o,
  output logic [BYTES_W-1:0]  out_bytes_o,
  output logic [CNT_W-1:0]    count_o
);

  localparam logic [BYTES_W-1:0] BLK = BYTES_W'(CACHE_BLOCK_SIZE);

  entry_t     slot     [MAX_RPCS];
  entry_t     ins_nxt  [MAX_RPCS];
  entry_t     even_nxt [MAX_RPCS];
  entry_t     odd_nxt  [MAX_RPCS];
  entry_t     sel_nxt  [MAX_RPCS];
  entry_t     new_e;
  entry_t     head_upd;
  logic       parity;
  logic       do_fetch, do_ins, head_done;
  logic [CNT_W-1:0] count;

  assign count_o     = count;
  assign out_data_o  = slot[0];
  assign out_bytes_o = (slot[0].remaining < BLK) ? slot[0].remaining : BLK;
  assign out_valid_o = !ap_rst && (slot[0].prio == PRIO_ACTIVE);
  assign in_ready_o  = !ap_rst && (count < CNT_W'(MAX_RPCS)) && !(out_valid_o && out_ready_i);
  assign do_fetch    = out_valid_o && out_ready_i;
  assign do_ins      = in_valid_i && in_ready_o;
  assign head_done   = slot[0].remaining <= BLK;

  // Incoming entry: the producer's PRIORITY is replaced by its credit state.
  always_comb begin
    new_e      = entry_t'(in_data_i);
    new_e.prio = (new_e.granted > new_e.dbuffered) ? PRIO_ACTIVE : PRIO_BLOCKED;
  end

  // Partial fetch: consume one block from the head, block it if credit runs out.
  always_comb begin
    head_upd           = slot[0];
    head_upd.remaining = slot[0].remaining - BLK;
    head_upd.dbuffered = slot[0].dbuffered + BLK;
    if (head_upd.dbuffered >= head_upd.granted) head_upd.prio = PRIO_BLOCKED;
  end

  // Insert network: new entry against the head, then pairs shift down one slot.
  srpt_cmp_swap u_ins_head (.a(slot[0]), .b(new_e), .lo(ins_nxt[0]), .hi(ins_nxt[1]));
  for (genvar k = 2; k < MAX_RPCS; k += 2) begin : g_ins
    srpt_cmp_swap u_cs (.a(slot[k-1]), .b(slot[k]), .lo(ins_nxt[k]), .hi(ins_nxt[k+1]));
  end

  // Even sort pass: pairs (0,1),(2,3),...
  for (genvar p = 0; p < MAX_RPCS/2; p++) begin : g_even
    srpt_cmp_swap u_cs (.a(slot[2*p]), .b(slot[2*p+1]),
                        .lo(even_nxt[2*p]), .hi(even_nxt[2*p+1]));
  end

  // Odd sort pass: pairs (1,2),...,(N-3,N-2); the two end slots hold.
  assign odd_nxt[0]          = slot[0];
  assign odd_nxt[MAX_RPCS-1] = slot[MAX_RPCS-1];
  for (genvar p = 0; p < MAX_RPCS/2 - 1; p++) begin : g_odd
    srpt_cmp_swap u_cs (.a(slot[2*p+1]), .b(slot[2*p+2]),
                        .lo(odd_nxt[2*p+1]), .hi(odd_nxt[2*p+2]));
  end

  // Select this cycle's operation: fetch, then insert, then one sort pass.
  always_comb begin
    for (int i = 0; i < MAX_RPCS; i++) sel_nxt[i] = slot[i];
    if (do_fetch) begin
      if (head_done) begin
        for (int i = 0; i < MAX_RPCS-1; i++) sel_nxt[i] = slot[i+1];
        sel_nxt[MAX_RPCS-1] = ENTRY_EMPTY;
      end else begin
        sel_nxt[0] = head_upd;
      end
    end else if (do_ins) begin
      for (int i = 0; i < MAX_RPCS; i++) sel_nxt[i] = ins_nxt[i];
    end else if (parity) begin
      for (int i = 0; i < MAX_RPCS; i++) sel_nxt[i] = odd_nxt[i];
    end else begin
      for (int i = 0; i < MAX_RPCS; i++) sel_nxt[i] = even_nxt[i];
    end
  end

  // State update; grants land on the post-selection view so same-cycle inserts see them.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      for (int i = 0; i < MAX_RPCS; i++) slot[i] <= ENTRY_EMPTY;
      count  <= '0;
      parity <= 1'b0;
    end else begin
      for (int i = 0; i < MAX_RPCS; i++)
        slot[i] <= apply_grant(sel_nxt[i], grant_valid_i, grant_rpc_id_i, grant_bytes_i);
      if (do_fetch && head_done) count <= count - 1'b1;
      else if (do_ins)           count <= count + 1'b1;
      if (!do_fetch && !do_ins)  parity <= ~parity;
    end
  end

endmodule

// File: tb/tb_srpt_fetch_sched.sv
// Directed bench for srpt_fetch_sched with hand-computed expectations.
module tb_srpt_fetch_sched;
  import srpt_pkg::*;

  localparam int N     = 8;
  localparam int CBS   = 64;
  localparam int CW    = $clog2(N + 1);

  logic                ap_clk = 1'b0;
  logic                ap_rst;
  logic                in_valid, in_ready;
  logic [ENTRY_W-1:0]  in_data;
  logic                grant_valid;
  logic [15:0]         grant_id;
  logic [19:0]         grant_bytes;
  logic                out_valid, out_ready;
  logic [ENTRY_W-1:0]  out_data;
  logic [19:0]         out_bytes;
  logic [CW-1:0]       count;
  entry_t              oe;

  int n_chk = 0;
  int n_err = 0;

  assign oe = entry_t'(out_data);

  srpt_fetch_sched #(.MAX_RPCS(N), .CACHE_BLOCK_SIZE(CBS)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .grant_valid_i(grant_valid), .grant_rpc_id_i(grant_id), .grant_bytes_i(grant_bytes),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_bytes_o(out_bytes), .count_o(count)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [ENTRY_W-1:0] mk(input int id, input int rem, input int dbuf, input int gr);
    entry_t e;
    e           = '0;
    e.rpc_id    = 16'(id);
    e.dbuff_id  = 10'(id);
    e.remaining = 20'(rem);
    e.dbuffered = 20'(dbuf);
    e.granted   = 20'(gr);
    return e;
  endfunction

  // Offer one entry from a negedge; returns at the negedge after acceptance.
  task automatic push(input logic [ENTRY_W-1:0] e);
    int w;
    w = 0;
    in_data  = e;
    in_valid = 1'b1;
    #1;
    while (!in_ready && w < 20) begin
      @(negedge ap_clk); #1; w++;
    end
    chk("push_ready", 32'(in_ready), 1);
    @(posedge ap_clk);
    @(negedge ap_clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) @(posedge ap_clk);
    @(negedge ap_clk);
    out_ready = 1'b0;
  endtask

  task automatic grant(input int id, input int bytes);
    grant_valid = 1'b1;
    grant_id    = 16'(id);
    grant_bytes = 20'(bytes);
    @(posedge ap_clk);
    @(negedge ap_clk);
    grant_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ids [4];
    int nf  [4];
    int lens[4];
    ids  = '{1, 2, 3, 4};
    lens = '{1000, 2000, 3000, 4000};
    nf   = '{16, 32, 47, 63};

    ap_rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    grant_valid = 1'b0; grant_id = '0; grant_bytes = '0;
    repeat (2) @(negedge ap_clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_count", 32'(count), 0);
    ap_rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(in_ready), 1);
    @(negedge ap_clk);

    // Single 512-byte RPC: eight full blocks, then the queue empties.
    push(mk(7, 512, 0, 512));
    chk("t1_valid_lat1", 32'(out_valid), 1);
    chk("t1_count", 32'(count), 1);
    for (int i = 0; i < 8; i++) begin
      chk("t1_id", 32'(oe.rpc_id), 7);
      chk("t1_bytes", 32'(out_bytes), 64);
      chk("t1_dbuf", 32'(oe.dbuffered), 32'(64 * i));
      out_ready = 1'b1;
      @(posedge ap_clk);
      @(negedge ap_clk);
    end
    out_ready = 1'b0;
    chk("t1_count_end", 32'(count), 0);
    repeat (4) @(negedge ap_clk);
    chk("t1_valid_end", 32'(out_valid), 0);

    // Out-of-order inserts sort to shortest-first.
    push(mk(4, 4000, 0, 4000));
    push(mk(1, 1000, 0, 1000));
    push(mk(3, 3000, 0, 3000));
    push(mk(2, 2000, 0, 2000));
    repeat (2 * N) @(negedge ap_clk);
    chk("t2_count", 32'(count), 4);
    for (int j = 0; j < 4; j++) begin
      chk("t2_head_valid", 32'(out_valid), 1);
      chk("t2_head_id", 32'(oe.rpc_id), 32'(ids[j]));
      chk("t2_head_rem", 32'(oe.remaining), 32'(lens[j]));
      drain(nf[j]);
    end
    chk("t2_count_end", 32'(count), 0);

    // Credit exhaustion blocks the head; a grant releases it.
    push(mk(9, 1000, 0, 128));
    drain(2);
    chk("t3_blocked", 32'(out_valid), 0);
    chk("t3_count", 32'(count), 1);
    chk("t3_prio", 32'(oe.prio), 32'(PRIO_BLOCKED));
    grant(9, 1000);
    chk("t3_unblocked", 32'(out_valid), 1);
    chk("t3_dbuf", 32'(oe.dbuffered), 128);
    chk("t3_granted", 32'(oe.granted), 1000);
    chk("t3_rem", 32'(oe.remaining), 872);
    drain(14);
    chk("t3_count_end", 32'(count), 0);

    // Grant to an absent RPC is dropped.
    grant(55, 900);
    push(mk(55, 64, 0, 10));
    chk("t3_absent_granted", 32'(oe.granted), 10);
    drain(1);

    // Grant in the insert cycle applies to the new entry.
    grant_valid = 1'b1; grant_id = 16'd11; grant_bytes = 20'd200;
    push(mk(11, 100, 0, 0));
    grant_valid = 1'b0;
    chk("t3_ins_grant_valid", 32'(out_valid), 1);
    chk("t3_ins_grant_gr", 32'(oe.granted), 200);
    chk("t3_ins_bytes", 32'(out_bytes), 64);
    drain(1);
    chk("t3_short_bytes", 32'(out_bytes), 36);
    chk("t3_short_dbuf", 32'(oe.dbuffered), 64);
    drain(1);
    chk("t3_count_end2", 32'(count), 0);

    // Fetch and insert in the same cycle: fetch wins, insert follows.
    push(mk(40, 64, 0, 1000));
    in_data = mk(41, 64, 0, 1000); in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("t4_ready_blocked", 32'(in_ready), 0);
    @(posedge ap_clk); @(negedge ap_clk);
    out_ready = 1'b0;
    chk("t4_count_fetch", 32'(count), 0);
    #1;
    chk("t4_ready_after", 32'(in_ready), 1);
    @(posedge ap_clk); @(negedge ap_clk);
    in_valid = 1'b0;
    chk("t4_count_ins", 32'(count), 1);
    chk("t4_head_id", 32'(oe.rpc_id), 41);
    drain(1);

    // Fill to capacity, extra offer held off until one entry drains.
    for (int i = 0; i < N; i++) push(mk(20 + i, 64, 0, 1000));
    chk("t5_full_count", 32'(count), N);
    in_data = mk(30, 64, 0, 1000); in_valid = 1'b1;
    repeat (3) begin
      #1;
      chk("t5_full_ready", 32'(in_ready), 0);
      @(negedge ap_clk);
    end
    chk("t5_full_hold", 32'(count), N);
    out_ready = 1'b1;
    #1;
    chk("t5_fetch_ready", 32'(in_ready), 0);
    @(posedge ap_clk); @(negedge ap_clk);
    out_ready = 1'b0;
    chk("t5_count_dec", 32'(count), N - 1);
    #1;
    chk("t5_ready_back", 32'(in_ready), 1);
    @(posedge ap_clk); @(negedge ap_clk);
    in_valid = 1'b0;
    chk("t5_count_refill", 32'(count), N);
    drain(N);
    chk("t5_count_end", 32'(count), 0);

    // Reset mid-stream discards the queue and any in-flight handshake.
    for (int i = 0; i < 5; i++) push(mk(60 + i, 1000, 0, 1000));
    chk("t6_count_pre", 32'(count), 5);
    ap_rst = 1'b1; in_data = mk(70, 64, 0, 1000); in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("t6_rst_ready", 32'(in_ready), 0);
    chk("t6_rst_valid", 32'(out_valid), 0);
    @(posedge ap_clk); @(negedge ap_clk);
    ap_rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("t6_count", 32'(count), 0);
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_head_prio", 32'(oe.prio), 32'(PRIO_EMPTY));
    chk("t6_head_id", 32'(oe.rpc_id), 0);
    @(negedge ap_clk);
    chk("t6_ready_after", 32'(in_ready), 1);
    repeat (N) @(negedge ap_clk);
    chk("t6_valid_idle", 32'(out_valid), 0);
    chk("t6_count_idle", 32'(count), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
